lzw_decode_unwind: RTL

LZW decompression core; the counterpart to the encoder's hash/dictionary path. Accepts 13-bit codes, walks the prefix/append dictionary RAMs to rebuild each string onto an internal LIFO stack, and emits the characters in forward order. Appends one new dictionary entry per code, using the standard rule including the KwKwK case. The dictionary is code-indexed rather than hashed, so decode needs no collision handling.

---
 rtl/lzw_decode_unwind_if.sv | 32 +++
 rtl/lzw_decode_unwind.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lzw_decode_unwind_if.sv
// rtl/lzw_decode_unwind_if.sv - code input, dictionary RAM and character output bundle for lzw_decode_unwind
interface lzw_decode_unwind_if #(
   parameter int CODE_W = 13,
   parameter int CHAR_W = 8
);
   logic [CODE_W-1:0] code_in;
   logic              code_valid;
   logic              code_ready;
   logic              dict_rd;
   logic [CODE_W-1:0] dict_addr;
   logic [CODE_W-1:0] prefix_data;
   logic [CHAR_W-1:0] append_data;
   logic              dict_we;
   logic [CODE_W-1:0] dict_waddr;
   logic [CODE_W-1:0] dict_wprefix;
   logic [CHAR_W-1:0] dict_wappend;
   logic [CHAR_W-1:0] char_out;
   logic              char_valid;
   logic              char_ready;

   modport slave (
      input  code_in, code_valid, prefix_data, append_data, char_ready,
      output code_ready, dict_rd, dict_addr, dict_we, dict_waddr, dict_wprefix, dict_wappend,
             char_out, char_valid
   );

   modport master (
      output code_in, code_valid, prefix_data, append_data, char_ready,
      input  code_ready, dict_rd, dict_addr, dict_we, dict_waddr, dict_wprefix, dict_wappend,
             char_out, char_valid
   );
endinterface

// File: rtl/lzw_decode_unwind.sv
// rtl/lzw_decode_unwind.sv - LZW decode core: walks prefix/append RAMs onto a LIFO, emits chars in order
// Optional feature macro LZW_CLEAR_CODE_EN makes code 256 a dictionary CLEAR.
module lzw_decode_unwind #(
   parameter int CODE_W      = 13,
   parameter int CHAR_W      = 8,
   parameter int STACK_DEPTH = 4096,
   parameter int MAX_CODE    = 8190
) (
   input  logic               clk_i,
   input  logic               rst_i,
   lzw_decode_unwind_if.slave bus,
   output logic [CODE_W-1:0]  next_code_o,
   output logic               busy_o,
   output logic               err_o
);
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = $clog2(STACK_DEPTH);
   localparam logic [CODE_W-1:0] LIT_CODE = CODE_W'(1 << CHAR_W);
`ifdef LZW_CLEAR_CODE_EN
   localparam logic [CODE_W-1:0] FIRST_FREE = LIT_CODE + CODE_W'(1);
`else
   localparam logic [CODE_W-1:0] FIRST_FREE = LIT_CODE;
`endif

   typedef enum logic [2:0] {S_IDLE, S_WALK, S_WAIT, S_UPDATE, S_POP} state_t;

   state_t            state_q;
   logic [CODE_W-1:0] cur_q, prev_code_q, code_q, next_code_q;
   logic [CODE_W-1:0] dict_waddr_q, dict_wprefix_q;
   logic [CHAR_W-1:0] first_char_q, char_out_q, dict_wappend_q;
   logic [SP_W-1:0]   sp_q;
   logic              first_q, err_q, code_ready_q, char_valid_q, dict_we_q;
   logic [CHAR_W-1:0] stack_q [STACK_DEPTH];

   logic              cur_lit_d, dict_rd_d, wr_en_d, stack_full_d;
   logic [IDX_W-1:0]  push_idx_d, top_idx_d, below_idx_d;

   always_comb begin
      cur_lit_d    = cur_q < LIT_CODE;
      dict_rd_d    = (state_q == S_WALK) && !cur_lit_d;
      wr_en_d      = !first_q && (next_code_q <= CODE_W'(MAX_CODE));
      stack_full_d = sp_q == SP_W'(STACK_DEPTH);
      push_idx_d   = sp_q[IDX_W-1:0];
      top_idx_d    = IDX_W'(sp_q - SP_W'(1));
      below_idx_d  = IDX_W'(sp_q - SP_W'(2));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= S_IDLE;
         cur_q          <= '0;
         prev_code_q    <= '0;
         code_q         <= '0;
         next_code_q    <= FIRST_FREE;
         first_char_q   <= '0;
         sp_q           <= '0;
         first_q        <= 1'b1;
         err_q          <= 1'b0;
         code_ready_q   <= 1'b1;
         char_valid_q   <= 1'b0;
         char_out_q     <= '0;
         dict_we_q      <= 1'b0;
         dict_waddr_q   <= '0;
         dict_wprefix_q <= '0;
         dict_wappend_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.code_valid && code_ready_q) begin
                  code_q <= bus.code_in;
`ifdef LZW_CLEAR_CODE_EN
                  if (bus.code_in == LIT_CODE) begin
                     next_code_q <= FIRST_FREE;
                     first_q     <= 1'b1;
                  end else
`endif
                  if (first_q && bus.code_in >= LIT_CODE) begin
                     err_q <= 1'b1;
                  end else if (bus.code_in < next_code_q) begin
                     cur_q        <= bus.code_in;
                     code_ready_q <= 1'b0;
                     state_q      <= S_WALK;
                  end else if (bus.code_in == next_code_q) begin
                     // KwKwK: string is prev + first char of prev; seed the stack with its tail
                     stack_q[push_idx_d] <= first_char_q;
                     sp_q                <= sp_q + SP_W'(1);
                     cur_q               <= prev_code_q;
                     code_ready_q        <= 1'b0;
                     state_q             <= S_WALK;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_WALK: begin
               if (!cur_lit_d) begin
                  state_q <= S_WAIT;
               end else if (stack_full_d) begin
                  err_q        <= 1'b1;
                  sp_q         <= '0;
                  code_ready_q <= 1'b1;
                  state_q      <= S_IDLE;
               end else begin
                  stack_q[push_idx_d] <= cur_q[CHAR_W-1:0];
                  sp_q                <= sp_q + SP_W'(1);
                  first_char_q        <= cur_q[CHAR_W-1:0];
                  dict_we_q           <= wr_en_d;
                  dict_waddr_q        <= next_code_q;
                  dict_wprefix_q      <= prev_code_q;
                  dict_wappend_q      <= cur_q[CHAR_W-1:0];
                  state_q             <= S_UPDATE;
               end
            end
            S_WAIT: begin
               if (stack_full_d) begin
                  err_q        <= 1'b1;
                  sp_q         <= '0;
                  code_ready_q <= 1'b1;
                  state_q      <= S_IDLE;
               end else begin
                  stack_q[push_idx_d] <= bus.append_data;
                  sp_q                <= sp_q + SP_W'(1);
                  cur_q               <= bus.prefix_data;
                  state_q             <= S_WALK;
               end
            end
            S_UPDATE: begin
               dict_we_q <= 1'b0;
               if (dict_we_q) next_code_q <= next_code_q + CODE_W'(1);
               prev_code_q  <= code_q;
               first_q      <= 1'b0;
               char_out_q   <= stack_q[top_idx_d];
               char_valid_q <= 1'b1;
               state_q      <= S_POP;
            end
            S_POP: begin
               if (bus.char_ready) begin
                  sp_q <= sp_q - SP_W'(1);
                  if (sp_q == SP_W'(1)) begin
                     char_valid_q <= 1'b0;
                     code_ready_q <= 1'b1;
                     state_q      <= S_IDLE;
                  end else begin
                     char_out_q <= stack_q[below_idx_d];
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.code_ready   = code_ready_q;
   assign bus.dict_rd      = dict_rd_d;
   assign bus.dict_addr    = dict_rd_d ? cur_q : '0;
   assign bus.dict_we      = dict_we_q;
   assign bus.dict_waddr   = dict_waddr_q;
   assign bus.dict_wprefix = dict_wprefix_q;
   assign bus.dict_wappend = dict_wappend_q;
   assign bus.char_out     = char_out_q;
   assign bus.char_valid   = char_valid_q;
   assign next_code_o      = next_code_q;
   assign busy_o           = state_q != S_IDLE;
   assign err_o            = err_q;
endmodule
